// File: rtl/score_pkg.sv
// Shared types and seven-segment constants for the score/scan display path.
// Segment vectors are ordered {a,b,c,d,e,f,g} and are active-low.
package score_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h01;
  localparam logic [6:0] SEG_1 = 7'h4F;
  localparam logic [6:0] SEG_2 = 7'h12;
  localparam logic [6:0] SEG_3 = 7'h06;
  localparam logic [6:0] SEG_4 = 7'h4C;
  localparam logic [6:0] SEG_5 = 7'h24;
  localparam logic [6:0] SEG_6 = 7'h20;
  localparam logic [6:0] SEG_7 = 7'h0F;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h04;

  // Codes 10-15 are not legal BCD; they fall through to a dark digit.
  function automatic logic [6:0] seg_decode(input bcd_digit_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_sat_counter.sv
// Multi-digit BCD up-counter that saturates at all nines instead of wrapping.
// A synchronous clear overrides an increment arriving in the same cycle.
module bcd_sat_counter
  import score_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  clr,
  output logic [DIGITS*4-1:0]   value
);

  logic [DIGITS*4-1:0] next_value;
  logic                all_nines;
  logic                carry;
  bcd_digit_t          digit;

  // Ripple a +1 through the digits, low to high, and flag the all-nines ceiling.
  always_comb begin
    next_value = value;
    all_nines  = 1'b1;
    carry      = 1'b1;
    digit      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = value[i*4 +: 4];
      if (digit != 4'd9) begin
        all_nines = 1'b0;
      end
      if (carry) begin
        if (digit >= 4'd9) begin
          next_value[i*4 +: 4] = 4'd0;
        end else begin
          next_value[i*4 +: 4] = digit + 4'd1;
          carry                = 1'b0;
        end
      end
    end
  end

  // Clear wins over increment; an increment at the ceiling leaves the value alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && !all_nines) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/score_scan_display.sv
// Per-player BCD coin/death counters multiplexed onto one common-anode
// seven-segment bank. Player 0 occupies the leftmost digits.
// Optional build macro SCORE_LEAD_ZERO_BLANK_EN blanks leading zeros in each
// field (the field's units digit is always shown).
module score_scan_display
  import score_pkg::*;
#(
  parameter int NUM_PLAYERS      = 2,
  parameter int DIGITS_PER_FIELD = 2,
  parameter int SCAN_DIV         = 12500
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_PLAYERS-1:0]                    coin_inc,
  input  logic [NUM_PLAYERS-1:0]                    death_inc,
  input  logic                                      score_clr,
  output logic [NUM_PLAYERS*DIGITS_PER_FIELD*4-1:0] coins_bcd,
  output logic [NUM_PLAYERS*DIGITS_PER_FIELD*4-1:0] deaths_bcd,
  output logic [6:0]                                seg,
  output logic [NUM_PLAYERS*2*DIGITS_PER_FIELD-1:0] an
);

  localparam int FW = DIGITS_PER_FIELD * 4;
  localparam int ND = NUM_PLAYERS * 2 * DIGITS_PER_FIELD;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(ND);
  localparam logic [ND-1:0] AN_ONE = ND'(1);

  logic [PW-1:0] presc;
  logic [IW-1:0] p_idx;
  logic          lit;
  logic [6:0]    shown_seg;
  bcd_digit_t    digit_at [ND];
`ifdef SCORE_LEAD_ZERO_BLANK_EN
  logic          lead_zero_at [ND];
`endif

  // One coin and one death counter per player, all cleared together.
  for (genvar q = 0; q < NUM_PLAYERS; q++) begin : g_player
    bcd_sat_counter #(.DIGITS(DIGITS_PER_FIELD)) u_coin (
      .clk   (clk),
      .rst   (rst),
      .inc   (coin_inc[q]),
      .clr   (score_clr),
      .value (coins_bcd[q*FW +: FW])
    );
    bcd_sat_counter #(.DIGITS(DIGITS_PER_FIELD)) u_death (
      .clk   (clk),
      .rst   (rst),
      .inc   (death_inc[q]),
      .clr   (score_clr),
      .value (deaths_bcd[q*FW +: FW])
    );
  end

  // Fixed wiring from each display position to the counter digit it shows.
  // Within a player's group the upper half is the coin field, the lower half
  // the death field; the highest-numbered group belongs to player 0.
  for (genvar p = 0; p < ND; p++) begin : g_pos
    localparam int  Q       = NUM_PLAYERS - 1 - p / (2 * DIGITS_PER_FIELD);
    localparam int  R       = p % (2 * DIGITS_PER_FIELD);
    localparam bit  IS_COIN = (R >= DIGITS_PER_FIELD);
    localparam int  DIG     = IS_COIN ? (R - DIGITS_PER_FIELD) : R;

    logic [FW-1:0] field;

    if (IS_COIN) begin : g_coin
      assign field = coins_bcd[Q*FW +: FW];
    end else begin : g_death
      assign field = deaths_bcd[Q*FW +: FW];
    end

    assign digit_at[p] = field[DIG*4 +: 4];

`ifdef SCORE_LEAD_ZERO_BLANK_EN
    if (DIG == 0) begin : g_units
      assign lead_zero_at[p] = 1'b0;
    end else begin : g_upper
      assign lead_zero_at[p] = ~|field[FW-1:DIG*4];
    end
`endif
  end

  // Pick the segment pattern for the digit currently in its scan slot.
  always_comb begin
`ifdef SCORE_LEAD_ZERO_BLANK_EN
    shown_seg = lead_zero_at[p_idx] ? SEG_BLANK : seg_decode(digit_at[p_idx]);
`else
    shown_seg = seg_decode(digit_at[p_idx]);
`endif
  end

  // Prescaler and digit index; the first terminal count after reset turns the
  // display on at digit 0 instead of skipping past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      p_idx <= '0;
      lit   <= 1'b0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      if (!lit) begin
        lit <= 1'b1;
      end else if (p_idx == IW'(ND - 1)) begin
        p_idx <= '0;
      end else begin
        p_idx <= p_idx + IW'(1);
      end
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Segment and anode pins are registered together and stay dark until lit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else if (lit) begin
      seg <= shown_seg;
      an  <= ~(AN_ONE << p_idx);
    end
  end

endmodule

// File: tb/tb_score_scan_display.sv
// Self-checking bench for score_scan_display (2 players, 2 digits, SCAN_DIV=4).
module tb_score_scan_display;

  localparam int NP  = 2;
  localparam int DPF = 2;
  localparam int SD  = 4;
  localparam int ND  = NP * 2 * DPF;
  localparam int MAXV = 99;

  logic                clk;
  logic                rst;
  logic [NP-1:0]       coin_inc;
  logic [NP-1:0]       death_inc;
  logic                score_clr;
  logic [NP*DPF*4-1:0] coins_bcd;
  logic [NP*DPF*4-1:0] deaths_bcd;
  logic [6:0]          seg;
  logic [ND-1:0]       an;

  int assertions = 0;
  int failures   = 0;

  // Reference model: plain integer scores, previous-cycle copy, edges since reset.
  int m_coin  [NP];
  int m_death [NP];
  int p_coin  [NP];
  int p_death [NP];
  int n_edges;

  score_scan_display #(
    .NUM_PLAYERS      (NP),
    .DIGITS_PER_FIELD (DPF),
    .SCAN_DIV         (SD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_inc   (coin_inc),
    .death_inc  (death_inc),
    .score_clr  (score_clr),
    .coins_bcd  (coins_bcd),
    .deaths_bcd (deaths_bcd),
    .seg        (seg),
    .an         (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Active-low segment pattern built from the list of lit segment letters.
  function automatic logic [6:0] ref_seg(input int d);
    string segs;
    logic [6:0] s;
    s = 7'h7F;
    case (d)
      0: segs = "abcdef";
      1: segs = "bc";
      2: segs = "abdeg";
      3: segs = "abcdg";
      4: segs = "bcfg";
      5: segs = "acdfg";
      6: segs = "acdefg";
      7: segs = "abc";
      8: segs = "abcdefg";
      9: segs = "abcdfg";
      default: segs = "";
    endcase
    for (int i = 0; i < segs.len(); i++) begin
      s[6 - (int'(segs[i]) - 97)] = 1'b0;
    end
    return s;
  endfunction

  function automatic logic [DPF*4-1:0] to_bcd(input int v);
    logic [DPF*4-1:0] b;
    b = '0;
    for (int i = 0; i < DPF; i++) begin
      b[i*4 +: 4] = 4'((v / (10 ** i)) % 10);
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of pulses, advance the model across the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic [NP-1:0] ci, input logic [NP-1:0] di, input logic clr);
    coin_inc  = ci;
    death_inc = di;
    score_clr = clr;
    @(posedge clk);
    p_coin  = m_coin;
    p_death = m_death;
    for (int q = 0; q < NP; q++) begin
      if (clr) begin
        m_coin[q]  = 0;
        m_death[q] = 0;
      end else begin
        if (ci[q] && m_coin[q] < MAXV)  m_coin[q]++;
        if (di[q] && m_death[q] < MAXV) m_death[q]++;
      end
    end
    n_edges++;
    @(negedge clk);
  endtask

  // Compare counters and display pins with what the model predicts.
  task automatic checkOutput();
    logic [NP*DPF*4-1:0] ec, ed;
    logic [ND-1:0]       ean;
    logic [6:0]          eseg;
    int t, pos, q, r, idx, val;
    for (int k = 0; k < NP; k++) begin
      ec[k*DPF*4 +: DPF*4] = to_bcd(m_coin[k]);
      ed[k*DPF*4 +: DPF*4] = to_bcd(m_death[k]);
    end
    ean  = '1;
    eseg = 7'h7F;
    t = (n_edges >= 1) ? (n_edges - 1) / SD : 0;
    if (t > 0) begin
      pos  = (t - 1) % ND;
      ean  = '1;
      ean[pos] = 1'b0;
      q    = NP - 1 - pos / (2 * DPF);
      r    = pos % (2 * DPF);
      idx  = (r >= DPF) ? r - DPF : r;
      val  = (r >= DPF) ? p_coin[q] : p_death[q];
      eseg = ref_seg((val / (10 ** idx)) % 10);
`ifdef SCORE_LEAD_ZERO_BLANK_EN
      if (idx > 0 && val < 10 ** idx) eseg = 7'h7F;
`endif
    end
    check("coins_bcd", 32'(coins_bcd), 32'(ec));
    check("deaths_bcd", 32'(deaths_bcd), 32'(ed));
    check("an", 32'(an), 32'(ean));
    check("seg", 32'(seg), 32'(eseg));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus('0, '0, 1'b0);
      checkOutput();
    end
  endtask

  task automatic waitForAn(input logic [ND-1:0] target, input int budget, input string name);
    int k;
    k = 0;
    while (an !== target && k < budget) begin
      applyStimulus('0, '0, 1'b0);
      checkOutput();
      k++;
    end
    check(name, 32'(an), 32'(target));
  endtask

  // Assert reset away from the clock edge; outputs must go dark at once.
  task automatic doReset();
    coin_inc  = '0;
    death_inc = '0;
    score_clr = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'(8'hFF));
    check("rst_coins", 32'(coins_bcd), 32'h0);
    @(negedge clk);
    @(negedge clk);
    for (int q = 0; q < NP; q++) begin
      m_coin[q] = 0; m_death[q] = 0; p_coin[q] = 0; p_death[q] = 0;
    end
    n_edges = 0;
    rst = 1'b0;
    checkOutput();
  endtask

  typedef struct {
    logic [NP-1:0] ci;
    logic [NP-1:0] di;
    logic          clr;
    int            reps;
    logic [15:0]   exp_coins;
    logic [15:0]   exp_deaths;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [ND-1:0] an_tab [8];
    int            dig_tab [8];
    int            k;
    logic [NP-1:0] ci, di;

    vecs[0]  = '{2'b01, 2'b00, 1'b0, 10, 16'h0010, 16'h0000};
    vecs[1]  = '{2'b00, 2'b10, 1'b0, 3,  16'h0010, 16'h0300};
    vecs[2]  = '{2'b01, 2'b01, 1'b0, 1,  16'h0011, 16'h0301};
    vecs[3]  = '{2'b11, 2'b11, 1'b1, 1,  16'h0000, 16'h0000};
    vecs[4]  = '{2'b01, 2'b00, 1'b0, 5,  16'h0005, 16'h0000};
    vecs[5]  = '{2'b00, 2'b01, 1'b0, 7,  16'h0005, 16'h0007};
    vecs[6]  = '{2'b01, 2'b01, 1'b1, 1,  16'h0000, 16'h0000};
    vecs[7]  = '{2'b01, 2'b00, 1'b0, 5,  16'h0005, 16'h0000};
    vecs[8]  = '{2'b00, 2'b01, 1'b0, 7,  16'h0005, 16'h0007};
    vecs[9]  = '{2'b01, 2'b01, 1'b0, 1,  16'h0006, 16'h0008};
    vecs[10] = '{2'b00, 2'b00, 1'b1, 1,  16'h0000, 16'h0000};
    vecs[11] = '{2'b10, 2'b00, 1'b0, 99, 16'h9900, 16'h0000};
    vecs[12] = '{2'b10, 2'b00, 1'b0, 1,  16'h9900, 16'h0000};
    vecs[13] = '{2'b10, 2'b00, 1'b0, 1,  16'h9900, 16'h0000};
    vecs[14] = '{2'b10, 2'b10, 1'b0, 2,  16'h9900, 16'h0200};

    an_tab  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    dig_tab = '{8, 7, 6, 5, 4, 3, 2, 1};

    rst = 1'b1;
    coin_inc = '0; death_inc = '0; score_clr = 1'b0;
    n_edges = 0;
    @(negedge clk);
    $display("[TB] reset");
    doReset();

    $display("[TB] counter vectors");
    for (int v = 0; v < 15; v++) begin
      for (int i = 0; i < vecs[v].reps; i++) begin
        applyStimulus(vecs[v].ci, vecs[v].di, vecs[v].clr);
        checkOutput();
      end
      check($sformatf("vec%0d_coins", v), 32'(coins_bcd), 32'(vecs[v].exp_coins));
      check($sformatf("vec%0d_deaths", v), 32'(deaths_bcd), 32'(vecs[v].exp_deaths));
    end

    $display("[TB] scan order");
    applyStimulus('0, '0, 1'b1);
    checkOutput();
    for (int i = 0; i < 78; i++) begin
      ci = {1'(i < 56), 1'(i < 12)};
      di = {1'(i < 78), 1'(i < 34)};
      applyStimulus(ci, di, 1'b0);
      checkOutput();
    end
    idle(2);
    waitForAn(8'hFE, ND * SD + SD + 2, "scan_find_fe");
    for (int s = 0; s < 8; s++) begin
      check($sformatf("scan_an%0d", s), 32'(an), 32'(an_tab[s]));
      check($sformatf("scan_seg%0d", s), 32'(seg), 32'(ref_seg(dig_tab[s])));
      idle(SD);
    end
    check("scan_wrap", 32'(an), 32'(8'hFE));

    $display("[TB] leading zero");
    applyStimulus('0, '0, 1'b1);
    checkOutput();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b01, '0, 1'b0);
      checkOutput();
    end
    idle(1);
    waitForAn(8'hBF, ND * SD + 2, "lz_find_bf");
    check("lz_units", 32'(seg), 32'(ref_seg(5)));
    idle(SD);
    check("lz_tens_an", 32'(an), 32'(8'h7F));
`ifdef SCORE_LEAD_ZERO_BLANK_EN
    check("lz_tens_seg", 32'(seg), 32'h7F);
`else
    check("lz_tens_seg", 32'(seg), 32'(ref_seg(0)));
`endif

    $display("[TB] random");
    for (int i = 0; i < 400; i++) begin
      for (int q = 0; q < NP; q++) begin
        ci[q] = ($urandom_range(0, 2) == 0);
        di[q] = ($urandom_range(0, 3) == 0);
      end
      applyStimulus(ci, di, ($urandom_range(0, 99) == 0));
      checkOutput();
    end

    $display("[TB] reset mid-scan");
    applyStimulus('0, '0, 1'b1);
    checkOutput();
    for (int i = 0; i < 42; i++) begin
      applyStimulus(2'b01, '0, 1'b0);
      checkOutput();
    end
    check("pre_reset_coins", 32'(coins_bcd), 32'h0042);
    waitForAn(8'hF7, ND * SD + 2, "find_p3");
    doReset();
    k = 0;
    while (an !== 8'hFE && k < 20) begin
      applyStimulus('0, '0, 1'b0);
      checkOutput();
      k++;
    end
    check("first_lit_cycles", 32'(k), 32'(SD + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
